// File: rtl/membus_arbiter_pkg.sv
// Shared types for the Membus arbiter: bus widths, owner encoding and FSM states.
package membus_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int MASK_W = XLEN / 8;

    typedef logic [XLEN-1:0]   Addr;
    typedef logic [XLEN-1:0]   UIntX;
    typedef logic [MASK_W-1:0] WMask;

    typedef enum logic {
        ARB_IFETCH = 1'b0,
        ARB_DATA   = 1'b1
    } ArbOwner;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT_RESP
    } ArbState;

endpackage

// File: rtl/membus_arbiter_arb_pick2.sv
// Two-way combinational pick: fixed data-over-ifetch with a starvation escape,
// or round-robin where the previous winner yields when both sides request.
module arb_pick2
    import membus_arbiter_pkg::*;
#(
    parameter bit RR_MODE = 1'b0
) (
    input  logic [1:0] req,
    input  ArbOwner    last_winner,
    input  logic       starve,
    output logic       grant_valid,
    output ArbOwner    winner
);

    always_comb begin
        grant_valid = |req;
        winner      = ARB_IFETCH;
        if (req == 2'b11) begin
            if (RR_MODE) begin
                winner = (last_winner == ARB_DATA) ? ARB_IFETCH : ARB_DATA;
            end else begin
                winner = starve ? ARB_IFETCH : ARB_DATA;
            end
        end else if (req[1]) begin
            winner = ARB_DATA;
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// Shares one Membus master port between instruction fetch and data access with a
// single outstanding transaction; responses are routed back to the recorded owner.
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter bit RR_MODE  = 1'b0,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_valid,
    output logic              i_ready,
    input  logic [XLEN-1:0]   i_addr,
    input  logic              i_wen,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [MASK_W-1:0] i_wmask,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,

    input  logic              d_valid,
    output logic              d_ready,
    input  logic [XLEN-1:0]   d_addr,
    input  logic              d_wen,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,

    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,

    output logic              busy,
    output ArbOwner           owner
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    ArbState    state;
    ArbState    state_next;
    ArbOwner    owner_q;
    ArbOwner    last_winner;
    ArbOwner    winner;
    logic [7:0] starve_cnt;
    logic       starve;
    logic       pick_valid;
    logic       issue;
    logic       grant;
    logic       handshake;
    logic       resp;

    assign starve = !RR_MODE && (starve_cnt == MAX_CNT);

    arb_pick2 #(
        .RR_MODE(RR_MODE)
    ) u_pick (
        .req        ({d_valid, i_valid}),
        .last_winner(last_winner),
        .starve     (starve),
        .grant_valid(pick_valid),
        .winner     (winner)
    );

    // Reset gates grants and responses so an abandoned transaction never leaks out.
    assign issue     = !rst && ((state == ARB_IDLE) || mem_rvalid);
    assign grant     = issue && pick_valid;
    assign handshake = grant && mem_ready;
    assign resp      = !rst && (state == ARB_WAIT_RESP) && mem_rvalid;

    always_comb begin
        mem_valid = grant;
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        if (grant) begin
            if (winner == ARB_DATA) begin
                mem_addr  = d_addr;
                mem_wen   = d_wen;
                mem_wdata = d_wdata;
                mem_wmask = d_wmask;
                d_ready   = mem_ready;
            end else begin
                mem_addr  = i_addr;
                mem_wen   = i_wen;
                mem_wdata = i_wdata;
                mem_wmask = i_wmask;
                i_ready   = mem_ready;
            end
        end
    end

    always_comb begin
        i_rvalid = resp && (owner_q == ARB_IFETCH);
        d_rvalid = resp && (owner_q == ARB_DATA);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

    // A same-cycle response and new handshake keeps the FSM in WAIT_RESP.
    always_comb begin
        state_next = state;
        if (handshake) begin
            state_next = ARB_WAIT_RESP;
        end else if (resp) begin
            state_next = ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            owner_q     <= ARB_IFETCH;
            last_winner <= ARB_IFETCH;
            starve_cnt  <= '0;
        end else begin
            state <= state_next;
            if (handshake) begin
                owner_q     <= winner;
                last_winner <= winner;
                if (!RR_MODE) begin
                    if (winner == ARB_IFETCH) begin
                        starve_cnt <= '0;
                    end else if (i_valid && (starve_cnt != MAX_CNT)) begin
                        starve_cnt <= starve_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign busy  = (state == ARB_WAIT_RESP);
    assign owner = owner_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Drives a fixed-priority (MAX_WAIT=2) and a round-robin arbiter with identical
// inputs and compares both against a transaction-level reference model every cycle.
module tb_membus_arbiter;
    import membus_arbiter_pkg::*;

    localparam int FIX_MAX_WAIT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              i_valid, i_wen, d_valid, d_wen, mem_ready, mem_rvalid;
    logic [XLEN-1:0]   i_addr, i_wdata, d_addr, d_wdata, mem_rdata;
    logic [MASK_W-1:0] i_wmask, d_wmask;

    logic              f_i_ready, f_i_rvalid, f_d_ready, f_d_rvalid, f_mem_valid, f_mem_wen, f_busy;
    logic [XLEN-1:0]   f_i_rdata, f_d_rdata, f_mem_addr, f_mem_wdata;
    logic [MASK_W-1:0] f_mem_wmask;
    logic              f_owner;
    logic              r_i_ready, r_i_rvalid, r_d_ready, r_d_rvalid, r_mem_valid, r_mem_wen, r_busy;
    logic [XLEN-1:0]   r_i_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
    logic [MASK_W-1:0] r_mem_wmask;
    logic              r_owner;

    int check_count = 0;
    int error_count = 0;

    bit m_busy[2];
    bit m_owner[2];
    bit m_last[2];
    int m_starve[2];

    membus_arbiter #(.RR_MODE(1'b0), .MAX_WAIT(FIX_MAX_WAIT)) u_fix (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(f_i_ready), .i_addr(i_addr), .i_wen(i_wen),
        .i_wdata(i_wdata), .i_wmask(i_wmask), .i_rvalid(f_i_rvalid), .i_rdata(f_i_rdata),
        .d_valid(d_valid), .d_ready(f_d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
        .mem_valid(f_mem_valid), .mem_ready(mem_ready), .mem_addr(f_mem_addr), .mem_wen(f_mem_wen),
        .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(f_busy), .owner(f_owner)
    );

    membus_arbiter #(.RR_MODE(1'b1), .MAX_WAIT(8)) u_rr (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(r_i_ready), .i_addr(i_addr), .i_wen(i_wen),
        .i_wdata(i_wdata), .i_wmask(i_wmask), .i_rvalid(r_i_rvalid), .i_rdata(r_i_rdata),
        .d_valid(d_valid), .d_ready(r_d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
        .mem_valid(r_mem_valid), .mem_ready(mem_ready), .mem_addr(r_mem_addr), .mem_wen(r_mem_wen),
        .mem_wdata(r_mem_wdata), .mem_wmask(r_mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(r_busy), .owner(r_owner)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit iv, input bit dv, input bit ready, input bit rv,
                                 input logic [31:0] rdata);
        i_valid    = iv;
        d_valid    = dv;
        mem_ready  = ready;
        mem_rvalid = rv;
        mem_rdata  = rdata;
    endtask

    // Reference model: one transaction in flight, response goes to whoever issued it.
    task automatic compareDut(input int k, input string nm,
                              input logic obs_mv, input logic [31:0] obs_ma, input logic obs_mwen,
                              input logic [31:0] obs_mwd, input logic [3:0] obs_mwm,
                              input logic obs_ir, input logic obs_dr,
                              input logic obs_irv, input logic [31:0] obs_ird,
                              input logic obs_drv, input logic [31:0] obs_drd,
                              input logic obs_busy, input logic obs_owner);
        bit rr, can_issue, pick_d, granted, responds;
        logic [31:0] e_addr, e_wdata;
        logic        e_wen;
        logic [3:0]  e_wmask;
        rr        = (k == 1);
        can_issue = !rst && (!m_busy[k] || mem_rvalid);
        if (i_valid && d_valid)
            pick_d = rr ? !m_last[k] : (m_starve[k] != FIX_MAX_WAIT);
        else
            pick_d = d_valid;
        granted  = can_issue && (i_valid || d_valid);
        responds = !rst && m_busy[k] && mem_rvalid;
        e_addr   = granted ? (pick_d ? d_addr : i_addr) : 32'h0;
        e_wen    = granted ? (pick_d ? d_wen : i_wen) : 1'b0;
        e_wdata  = granted ? (pick_d ? d_wdata : i_wdata) : 32'h0;
        e_wmask  = granted ? (pick_d ? d_wmask : i_wmask) : 4'h0;

        checkOutput({nm, ".mem_valid"}, 32'(obs_mv), 32'(granted));
        checkOutput({nm, ".mem_addr"}, obs_ma, e_addr);
        checkOutput({nm, ".mem_wen"}, 32'(obs_mwen), 32'(e_wen));
        checkOutput({nm, ".mem_wdata"}, obs_mwd, e_wdata);
        checkOutput({nm, ".mem_wmask"}, 32'(obs_mwm), 32'(e_wmask));
        checkOutput({nm, ".i_ready"}, 32'(obs_ir), 32'(granted && !pick_d && mem_ready));
        checkOutput({nm, ".d_ready"}, 32'(obs_dr), 32'(granted && pick_d && mem_ready));
        checkOutput({nm, ".i_rvalid"}, 32'(obs_irv), 32'(responds && !m_owner[k]));
        checkOutput({nm, ".i_rdata"}, obs_ird, (responds && !m_owner[k]) ? mem_rdata : 32'h0);
        checkOutput({nm, ".d_rvalid"}, 32'(obs_drv), 32'(responds && m_owner[k]));
        checkOutput({nm, ".d_rdata"}, obs_drd, (responds && m_owner[k]) ? mem_rdata : 32'h0);
        checkOutput({nm, ".busy"}, 32'(obs_busy), 32'(m_busy[k]));
        if (m_busy[k])
            checkOutput({nm, ".owner"}, 32'(obs_owner), 32'(m_owner[k]));

        if (rst) begin
            m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 0; m_starve[k] = 0;
        end else if (granted && mem_ready) begin
            m_busy[k]  = 1;
            m_owner[k] = pick_d;
            m_last[k]  = pick_d;
            if (!rr) begin
                if (!pick_d) m_starve[k] = 0;
                else if (i_valid && m_starve[k] < FIX_MAX_WAIT) m_starve[k]++;
            end
        end else if (m_busy[k] && mem_rvalid) begin
            m_busy[k] = 0;
        end
    endtask

    task automatic evalCycle();
        @(negedge clk);
        compareDut(0, "fix", f_mem_valid, f_mem_addr, f_mem_wen, f_mem_wdata, f_mem_wmask,
                   f_i_ready, f_d_ready, f_i_rvalid, f_i_rdata, f_d_rvalid, f_d_rdata, f_busy, f_owner);
        compareDut(1, "rr", r_mem_valid, r_mem_addr, r_mem_wen, r_mem_wdata, r_mem_wmask,
                   r_i_ready, r_d_ready, r_i_rvalid, r_i_rdata, r_d_rvalid, r_d_rdata, r_busy, r_owner);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'h0);
        repeat (2) begin
            evalCycle();
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] fix_order[6];
        logic [1:0] rr_order[6];
        fix_order = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
        rr_order  = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        i_addr = 32'h0; i_wen = 0; i_wdata = 32'h0; i_wmask = 4'h0;
        d_addr = 32'h0; d_wen = 0; d_wdata = 32'h0; d_wmask = 4'h0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'h0);
        advance();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 0; m_starve[k] = 0;
        end
        doReset();
        checkOutput("reset.busy", 32'(f_busy), 32'h0);

        // Lone instruction fetch, response one cycle later.
        i_addr = 32'h0000_1000;
        applyStimulus(1, 0, 1, 0, 32'h0);
        evalCycle();
        checkOutput("ifetch.i_ready", 32'(f_i_ready), 32'h1);
        checkOutput("ifetch.mem_addr", f_mem_addr, 32'h0000_1000);
        advance();
        applyStimulus(0, 0, 1, 1, 32'hDEAD_BEEF);
        evalCycle();
        checkOutput("ifetch.i_rvalid", 32'(f_i_rvalid), 32'h1);
        checkOutput("ifetch.i_rdata", f_i_rdata, 32'hDEAD_BEEF);
        checkOutput("ifetch.d_rvalid", 32'(f_d_rvalid), 32'h0);
        advance();

        // Both requesting continuously: starvation escape vs. alternation.
        doReset();
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1, 1, 1, n != 0, 32'h100 + 32'(n));
            evalCycle();
            checkOutput($sformatf("fix.order%0d", n),
                        32'(f_d_ready ? 2'd1 : f_i_ready ? 2'd0 : 2'd3), 32'(fix_order[n]));
            checkOutput($sformatf("rr.order%0d", n),
                        32'(r_d_ready ? 2'd1 : r_i_ready ? 2'd0 : 2'd3), 32'(rr_order[n]));
            advance();
        end

        // Write held while memory stalls, accepted on the fourth cycle.
        doReset();
        d_addr = 32'h0000_2000; d_wen = 1; d_wdata = 32'h1234_5678; d_wmask = 4'b0011;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(0, 1, n == 3, 0, 32'h0);
            evalCycle();
            checkOutput("stall.mem_valid", 32'(f_mem_valid), 32'h1);
            checkOutput("stall.mem_wdata", f_mem_wdata, 32'h1234_5678);
            checkOutput("stall.mem_wmask", 32'(f_mem_wmask), 32'h3);
            checkOutput("stall.d_ready", 32'(f_d_ready), 32'(n == 3));
            advance();
        end

        // Data response and instruction issue in the same cycle.
        applyStimulus(1, 0, 1, 1, 32'hCAFE_0001);
        evalCycle();
        checkOutput("b2b.busy", 32'(f_busy), 32'h1);
        checkOutput("b2b.owner_d", 32'(f_owner), 32'h1);
        checkOutput("b2b.d_rvalid", 32'(f_d_rvalid), 32'h1);
        checkOutput("b2b.i_ready", 32'(r_i_ready), 32'h1);
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0);
        evalCycle();
        checkOutput("b2b.next_busy", 32'(r_busy), 32'h1);
        checkOutput("b2b.next_owner", 32'(f_owner), 32'h0);
        advance();

        // Reset abandons the in-flight fetch; the late response is dropped.
        rst = 1'b1;
        evalCycle();
        advance();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 32'hBAD0_BAD0);
        evalCycle();
        checkOutput("rstmid.i_rvalid", 32'(f_i_rvalid), 32'h0);
        checkOutput("rstmid.d_rvalid", 32'(f_d_rvalid), 32'h0);
        checkOutput("rstmid.busy", 32'(f_busy), 32'h0);
        advance();
        applyStimulus(1, 0, 1, 0, 32'h0);
        evalCycle();
        checkOutput("rstmid.i_ready", 32'(f_i_ready), 32'h1);
        advance();

        // Random traffic, including occasional reset.
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 59) == 0);
            i_addr  = $urandom; i_wen = 1'($urandom); i_wdata = $urandom; i_wmask = 4'($urandom);
            d_addr  = $urandom; d_wen = 1'($urandom); d_wdata = $urandom; d_wmask = 4'($urandom);
            applyStimulus(1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                          1'($urandom), $urandom);
            evalCycle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
